// File: rtl/irq_stim_gen.sv
// irq_stim_gen: power-up reset sequencer for the CPU core plus NCH periodic interrupt sources
// that hold until acknowledged and count lost periods. Macro IRQ_JITTER_EN adds 0..3 cycles of LFSR jitter per period.
module irq_stim_gen #(
    parameter int NCH      = 2,
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 16,
    parameter int MAX_IRQ  = 255,
    parameter int MISS_W   = 4
) (
    input  logic                  clk_gl,
    input  logic                  rst,
    input  logic                  en,
    input  logic [NCH*CNT_W-1:0]  cfg_period,
    input  logic [NCH-1:0]        irq_ack,
    output logic                  core_rst_n,
    output logic [NCH-1:0]        irq,
    output logic [NCH*MISS_W-1:0] miss_cnt,
    output logic [NCH-1:0]        overrun,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;

    localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
    localparam logic [7:0]        ISSUE_MAX = 8'(MAX_IRQ);
    localparam logic [MISS_W-1:0] MISS_SAT  = '1;

    state_t            state, state_next;
    logic [HOLD_W-1:0] hold_cnt;
    logic [CNT_W-1:0]  period [NCH];
    logic [CNT_W-1:0]  phase  [NCH];
    logic [7:0]        issued [NCH];
    logic [MISS_W-1:0] miss   [NCH];
    logic [NCH-1:0]    retired, wrap, fire;
    logic              running;

`ifdef IRQ_JITTER_EN
    logic [15:0] lfsr;
    logic [1:0]  jit [NCH];
`endif

    assign running = (state == RUN) && en;

    // A channel wraps on its (possibly jittered) period; it only fires while it still has interrupts to issue.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            period[i]  = cfg_period[i*CNT_W +: CNT_W];
            retired[i] = (period[i] == '0) || (issued[i] == ISSUE_MAX);
`ifdef IRQ_JITTER_EN
            wrap[i]    = running && (period[i] != '0) &&
                         ({1'b0, phase[i]} == {1'b0, period[i]} + (CNT_W+1)'(jit[i]) - 1'b1);
`else
            wrap[i]    = running && (period[i] != '0) && (phase[i] == period[i] - 1'b1);
`endif
            fire[i]    = wrap[i] && !retired[i];
        end
    end

    // NOTE: state_next takes its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (en) state_next = HOLD;
            HOLD: begin
                if (!en)                  state_next = IDLE;
                else if (hold_cnt == '0)  state_next = RUN;
            end
            RUN:  if ((&retired) && (irq == '0)) state_next = DONE;
            DONE: state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk_gl or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            core_rst_n <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_next;
            core_rst_n <= (state_next == RUN) || (state_next == DONE);
            done       <= (state_next == DONE);
            if (state == IDLE && en)
                hold_cnt <= HOLD_LOAD;
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;
        end
    end

    // NOTE: the per-channel arrays are plain registers, not RAM, so they take the async reset like all other state.
    always_ff @(posedge clk_gl or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NCH; i++) begin
                phase[i]  <= '0;
                issued[i] <= '0;
                miss[i]   <= '0;
            end
            irq     <= '0;
            overrun <= '0;
        end else if (state == DONE) begin
            irq <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NCH; i++) begin
                if (period[i] == '0)
                    phase[i] <= '0;
                else if (running)
                    phase[i] <= wrap[i] ? '0 : phase[i] + 1'b1;

                // An ack landing with a fire is consumed by the new request, so it is not a miss.
                if (fire[i]) begin
                    irq[i] <= 1'b1;
                    if (irq[i] && !irq_ack[i]) begin
                        if (miss[i] != MISS_SAT)
                            miss[i] <= miss[i] + 1'b1;
                        overrun[i] <= 1'b1;
                    end else begin
                        issued[i] <= issued[i] + 1'b1;
                    end
                end else if (irq_ack[i]) begin
                    irq[i] <= 1'b0;
                end
            end
        end
    end

`ifdef IRQ_JITTER_EN
    // Right-shifting Galois LFSR, taps 16,14,13,11; a channel latches fresh jitter at each wrap.
    always_ff @(posedge clk_gl or negedge rst) begin
        if (!rst) begin
            lfsr <= 16'hACE1;
            for (int i = 0; i < NCH; i++)
                jit[i] <= '0;
        end else if (state == RUN) begin
            lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            for (int i = 0; i < NCH; i++)
                if (wrap[i])
                    jit[i] <= lfsr[1:0];
        end
    end
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_miss
        assign miss_cnt[g*MISS_W +: MISS_W] = miss[g];
    end

endmodule
